pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core; sits beside the IF/ID/EX/MEM pipeline registers and drives their stall/flush/bubble enables. It detects load-use hazards against the instruction in ID and holds fetch while a decoded branch resolves in EX, replacing ID's ad-hoc branch NOP signal. It also freezes the whole pipe while data memory is not ready. Saturating stall statistics and a sticky memory-timeout flag are provided for debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard-detect inputs from ID/EX/MEM
// and the stall/flush/bubble enables plus debug status going back to the pipe.
interface pipe_hazard_ctrl_if;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_br_valid;
  logic        ex_br_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_stall;
  logic        pc_redirect;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_stall;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_br_valid, ex_br_taken, mem_req, mem_ready,
    input  pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_bubble,
           ex_mem_stall, state, stall_cycles, mem_timeout
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_br_valid, ex_br_taken, mem_req, mem_ready,
    output pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_bubble,
           ex_mem_stall, state, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, branch fetch hold,
// data-memory freeze, plus saturating stall statistics and a sticky memory timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt, stall_cnt_d;
  logic                timeout_q, timeout_d;

  logic memwait_c, loaduse_c, isbr_c, uses_rs2_c;
  logic pc_stall_c, pc_redirect_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_bubble_c, ex_mem_stall_c;

  // Hazard conditions; rs2 only matters for R-type, store and branch encodings.
  assign memwait_c  = bus.mem_req & ~bus.mem_ready;
  assign uses_rs2_c = (bus.id_opcode == OP_OP) | (bus.id_opcode == OP_STORE) |
                      (bus.id_opcode == OP_BRANCH);
  assign loaduse_c  = bus.id_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                      ((bus.ex_rd == bus.id_rs1) | ((bus.ex_rd == bus.id_rs2) & uses_rs2_c));
  assign isbr_c     = bus.id_valid & (bus.id_opcode == OP_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ret_q      <= RUN;
      wait_cnt_q <= '0;
      stall_cnt  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      stall_cnt  <= stall_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    pc_stall_c     = 1'b0;
    pc_redirect_c  = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    ex_mem_stall_c = 1'b0;

    case (state_q)
      RUN: begin
        if (memwait_c) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
          ret_d          = RUN;
          wait_cnt_d     = '0;
          state_d        = MEM_WAIT;
        end else if (loaduse_c) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (isbr_c) begin
          pc_stall_c     = 1'b1;
          if_id_flush_c  = 1'b1;
          state_d        = BR_HOLD;
        end
      end

      BR_HOLD: begin
        if (memwait_c) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
          ret_d          = BR_HOLD;
          wait_cnt_d     = '0;
          state_d        = MEM_WAIT;
        end else if (bus.ex_br_valid) begin
          pc_redirect_c  = bus.ex_br_taken;
          if_id_flush_c  = bus.ex_br_taken;
          state_d        = RUN;
        end else begin
          pc_stall_c     = 1'b1;
          if_id_flush_c  = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (!bus.mem_ready) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
        end else begin
          state_d        = ret_q;
        end
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        // Flag rises on the edge where the counter arrives at MEM_TIMEOUT.
        if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) timeout_d = 1'b1;
      end

      default: state_d = RUN;
    endcase

    stall_cnt_d = (pc_stall_c && (stall_cnt != '1)) ? stall_cnt + CNT_W'(1) : stall_cnt;
  end

  // Everything observed by the pipe is held at zero while reset is asserted.
  assign bus.pc_stall     = rst_n & pc_stall_c;
  assign bus.pc_redirect  = rst_n & pc_redirect_c;
  assign bus.if_id_stall  = rst_n & if_id_stall_c;
  assign bus.if_id_flush  = rst_n & if_id_flush_c;
  assign bus.id_ex_bubble = rst_n & id_ex_bubble_c;
  assign bus.ex_mem_stall = rst_n & ex_mem_stall_c;
  assign bus.state        = rst_n ? 2'(state_q) : 2'(RUN);
  assign bus.stall_cycles = rst_n ? stall_cnt : '0;
  assign bus.mem_timeout  = rst_n & timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 15;

  logic clk;
  logic rst_n;
  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0=run, 1=waiting for branch, 2=waiting for memory.
  int m_mode, m_ret, m_wait, m_stall;
  bit m_to;
  bit e_ps, e_rd, e_ifs, e_fl, e_bub, e_exs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_memwait();
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic bit f_loaduse();
    bit rs2_used;
    rs2_used = bus.id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    return bus.id_valid && bus.ex_mem_read && bus.ex_rd != 0 &&
           (bus.ex_rd == bus.id_rs1 || (bus.ex_rd == bus.id_rs2 && rs2_used));
  endfunction

  function automatic bit f_isbr();
    return bus.id_valid && bus.id_opcode == 7'b1100011;
  endfunction

  task automatic model_eval();
    {e_ps, e_rd, e_ifs, e_fl, e_bub, e_exs} = '0;
    if (rst_n) begin
      if (m_mode == 2) begin
        if (!bus.mem_ready) {e_ps, e_ifs, e_exs} = 3'b111;
      end else if (f_memwait()) begin
        {e_ps, e_ifs, e_exs} = 3'b111;
      end else if (m_mode == 1) begin
        if (!bus.ex_br_valid)     {e_ps, e_fl} = 2'b11;
        else if (bus.ex_br_taken) {e_rd, e_fl} = 2'b11;
      end else if (f_loaduse()) begin
        {e_ps, e_ifs, e_bub} = 3'b111;
      end else if (f_isbr()) begin
        {e_ps, e_fl} = 2'b11;
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_ret = 0; m_wait = 0; m_stall = 0; m_to = 0;
      return;
    end
    if (e_ps && m_stall < 65535) m_stall++;
    if (m_mode == 2) begin
      m_wait++;
      if (m_wait == TIMEOUT) m_to = 1;
      if (bus.mem_ready) m_mode = m_ret;
    end else if (f_memwait()) begin
      m_ret = m_mode; m_mode = 2; m_wait = 0;
    end else if (m_mode == 1) begin
      if (bus.ex_br_valid) m_mode = 0;
    end else if (!f_loaduse() && f_isbr()) begin
      m_mode = 1;
    end
  endtask

  // Let combinational outputs settle, then compare every output with the model.
  task automatic settle();
    #1;
    model_eval();
    chk("pc_stall",     32'(bus.pc_stall),     32'(e_ps));
    chk("pc_redirect",  32'(bus.pc_redirect),  32'(e_rd));
    chk("if_id_stall",  32'(bus.if_id_stall),  32'(e_ifs));
    chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
    chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
    chk("ex_mem_stall", 32'(bus.ex_mem_stall), 32'(e_exs));
    chk("state",        32'(bus.state),        32'(rst_n ? m_mode : 0));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(rst_n ? m_stall : 0));
    chk("mem_timeout",  32'(bus.mem_timeout),  32'(rst_n ? m_to : 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.ex_mem_read = 0; bus.ex_rd = 0; bus.ex_br_valid = 0; bus.ex_br_taken = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic id_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.id_valid = 1; bus.id_opcode = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
  endtask

  task automatic do_reset();
    rst_n = 0; idle();
    settle();
    chk("rst_pc_stall", 32'(bus.pc_stall), 32'd0);
    chk("rst_state",    32'(bus.state),    32'd0);
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0] ops [5];

  initial begin
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011};
    rst_n = 0; idle();
    m_mode = 0; m_ret = 0; m_wait = 0; m_stall = 0; m_to = 0;
    @(negedge clk);
    do_reset();

    // Load-use against rs2 of an R-type: exactly one stall cycle.
    id_instr(7'b0110011, 5'd7, 5'd5); bus.ex_mem_read = 1; bus.ex_rd = 5'd5;
    settle();
    chk("lu_stall",  32'({bus.pc_stall, bus.if_id_stall, bus.id_ex_bubble}), 32'b111);
    chk("lu_state",  32'(bus.state), 32'd0);
    tick();
    bus.ex_mem_read = 0; bus.ex_rd = 5'd0;
    settle();
    chk("lu_gone", 32'(bus.pc_stall), 32'd0);
    tick();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd0; id_instr(7'b0110011, 5'd0, 5'd0);
    settle();
    chk("lu_x0", 32'(bus.pc_stall), 32'd0);
    tick();

    // I-type ignores its rs2 field; stores do not.
    id_instr(7'b0010011, 5'd7, 5'd5); bus.ex_mem_read = 1; bus.ex_rd = 5'd5;
    settle();
    chk("itype_rs2", 32'(bus.pc_stall), 32'd0);
    tick();
    id_instr(7'b0100011, 5'd7, 5'd5);
    settle();
    chk("store_rs2", 32'(bus.id_ex_bubble), 32'd1);
    tick();

    // Branch taken.
    idle(); id_instr(7'b1100011, 5'd1, 5'd2);
    settle();
    chk("br_dec", 32'({bus.pc_stall, bus.if_id_flush, bus.state}), 32'b1100);
    tick();
    idle(); bus.ex_br_valid = 1; bus.ex_br_taken = 1;
    settle();
    chk("br_taken", 32'({bus.pc_redirect, bus.if_id_flush, bus.pc_stall, bus.state}), 32'b11001);
    tick();
    idle();
    settle();
    chk("br_back", 32'(bus.state), 32'd0);
    tick();

    // Branch not taken, one extra EX cycle.
    id_instr(7'b1100011, 5'd1, 5'd2);
    settle(); tick();
    idle();
    settle();
    chk("br_wait", 32'({bus.pc_stall, bus.if_id_flush}), 32'b11);
    tick();
    bus.ex_br_valid = 1; bus.ex_br_taken = 0;
    settle();
    chk("br_nt", 32'({bus.pc_stall, bus.pc_redirect, bus.if_id_flush}), 32'b000);
    tick();

    // Memory stall while a branch is held: resolution ignored until released.
    idle(); id_instr(7'b1100011, 5'd3, 5'd4);
    settle(); tick();
    idle(); bus.mem_req = 1; bus.mem_ready = 0; bus.ex_br_valid = 1; bus.ex_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("brmem_frz", 32'({bus.pc_stall, bus.if_id_stall, bus.ex_mem_stall, bus.pc_redirect}), 32'b1110);
      chk("brmem_st",  32'(bus.state), (i == 0) ? 32'd1 : 32'd2);
      tick();
    end
    bus.mem_ready = 1;
    settle();
    chk("brmem_rel", 32'({bus.pc_stall, bus.pc_redirect, bus.state}), 32'b0010);
    tick();
    bus.mem_req = 0; bus.mem_ready = 0;
    settle();
    chk("brmem_res", 32'({bus.pc_redirect, bus.state}), 32'b101);
    tick();

    // Timeout: flag visible from the 16th waiting cycle, sticky until reset.
    do_reset();
    bus.mem_req = 1; bus.mem_ready = 0;
    settle(); tick();
    for (int i = 1; i <= 20; i++) begin
      settle();
      chk("to_flag", 32'(bus.mem_timeout), (i >= 16) ? 32'd1 : 32'd0);
      tick();
    end
    bus.mem_ready = 1;
    settle();
    chk("to_rel", 32'({bus.mem_timeout, bus.pc_stall}), 32'b10);
    tick();
    idle();
    settle();
    chk("to_sticky", 32'(bus.mem_timeout), 32'd1);
    tick();
    do_reset();
    settle();
    chk("to_cleared", 32'(bus.mem_timeout), 32'd0);
    tick();

    // Stall counter saturation, then reset in the middle of a memory wait.
    bus.mem_req = 1; bus.mem_ready = 0;
    settle(); tick();
    force dut.stall_cnt = 16'hFFFD;
    #1 release dut.stall_cnt;
    m_stall = 16'hFFFD;
    settle();
    chk("sat_pre", 32'(bus.stall_cycles), 32'hFFFD);
    tick(); settle(); tick(); settle();
    chk("sat_max", 32'(bus.stall_cycles), 32'hFFFF);
    tick(); settle();
    chk("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
    tick();
    rst_n = 0;
    settle();
    chk("rst_mw_out", 32'({bus.pc_stall, bus.ex_mem_stall, bus.state}), 32'd0);
    tick();
    rst_n = 1; bus.mem_req = 0;
    settle();
    chk("rst_mw_state", 32'(bus.state), 32'd0);
    chk("rst_mw_cnt",   32'(bus.stall_cycles), 32'd0);
    tick();

    // Randomized traffic with a small register space to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_opcode   = ops[$urandom_range(0, 4)];
      bus.id_rs1      = 5'($urandom_range(0, 7));
      bus.id_rs2      = 5'($urandom_range(0, 7));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rd       = 5'($urandom_range(0, 7));
      bus.ex_br_valid = ($urandom_range(0, 2) == 0);
      bus.ex_br_taken = 1'($urandom_range(0, 1));
      bus.mem_req     = ($urandom_range(0, 3) == 0);
      bus.mem_ready   = ($urandom_range(0, 2) == 0);
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
